snake_pacer: RTL and testbench
==============================

# snake_pacer

Game-speed pacer and scorekeeper sitting directly upstream of the snake game core. It generates the `o_phase` toggle that the core consumes as its `i_phase` input (one game tick per toggle), shortens the toggle period as the snake eats apples, and freezes the pacing once the core reports failure or success. It also counts eaten apples as a two-digit BCD score for display or debug pins.

## Interface
Parameters:
- `PERIOD_START`, default 6250000: initial clock cycles between phase toggles (0.25 s at 25 MHz).
- `PERIOD_STEP`, default 250000: period reduction per level-up.
- `PERIOD_MIN`, default 1250000: floor on the period.
- `APPLES_PER_LEVEL`, default 4: eats per level-up, 1..15.
- `CNT_W`, default 23: width of the period counter and register; must hold `PERIOD_START`.

Ports:
- `clk` in 1: system/VGA clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_eat` in 1: core eat indication; level, counted on rising edge.
- `i_failure` in 1: core sticky failure flag.
- `i_success` in 1: core sticky success flag.
- `i_pause` in 1: level; while high, pacing stops.
- `o_phase` out 1: toggles once per game tick; feeds core `i_phase`.
- `o_score` out 8: BCD score, `[7:4]` tens, `[3:0]` units.
- `o_level` out 4: current speed level.
- `o_state` out 2: 0 RUN, 1 PAUSE, 2 LOST, 3 WON.

## Operation
- Reset values: `o_phase`=0, `o_score`=8'h00, `o_level`=0, `o_state`=RUN, period register=`PERIOD_START`, counter=0, apples-in-level=0, eat edge register=0.
- FSM:
  - RUN→LOST when `i_failure`=1. LOST has priority over WON when both inputs are 1 in the same cycle.
  - RUN→WON when `i_success`=1.
  - RUN→PAUSE when `i_pause`=1 and neither flag is set.
  - PAUSE→RUN when `i_pause`=0.
  - PAUSE→LOST/WON on the flags, same priority.
  - LOST and WON are terminal until `rst_n`.
- Counter, RUN only:
  - Increments each cycle.
  - When counter ≥ period−1: counter←0 and `o_phase` toggles.
  - The ≥ compare handles a period shrinking below the current count.
- Counter in PAUSE: held. Counter in LOST/WON: held; `o_phase` frozen.
- Eat detection:
  - Eat event = `i_eat`=1 while registered previous `i_eat`=0.
  - Events are counted in RUN and PAUSE, and in the cycle RUN→LOST/WON is taken (the core asserts eat and the flags together). Ignored once in LOST/WON.
- Score: BCD increment on each eat event (units 9→0 carries into tens). Saturates at 8'h99.
- Level-up:
  - Apples-in-level increments per event.
  - On reaching `APPLES_PER_LEVEL`: apples-in-level←0, `o_level` increments (saturating at 15), and period ← max(period−`PERIOD_STEP`, `PERIOD_MIN`).
  - The subtraction is done at CNT_W+1 bits to detect underflow; on underflow, period=`PERIOD_MIN`.
- Asserting `rst_n` mid-game immediately returns every register to its reset value. The core is reset on the same `rst_n`, so `o_phase`=0 matches its sampled phase.

## Timing
- Toggle cadence in steady RUN: exactly `period` cycles between `o_phase` edges. First toggle after reset comes `PERIOD_START` cycles after `rst_n` deasserts.
- Eat latency:
  - `o_score` updates on the clock edge following the first cycle `i_eat` is high (1 cycle).
  - `o_level` and period update in the same cycle as the score.
- Period change:
  - A wrap occurring on the same edge as a period update uses the old period.
  - Counting after that edge uses the new period.
- `o_state` is registered: a flag high at edge N gives `o_state` changed and no toggle from edge N+1 onward. A toggle already scheduled at edge N still occurs.
- Pause: the counter value is preserved. After resume, the remaining cycles to the toggle equal those remaining at pause entry.
- Held `i_eat` counts once; re-arming needs at least one low cycle.

## Test plan
Parameters for all scenarios: `PERIOD_START`=10, `PERIOD_STEP`=3, `PERIOD_MIN`=4, `APPLES_PER_LEVEL`=2, `CNT_W`=5.
1. Release reset, idle 40 cycles → `o_phase` toggles every 10 cycles, first at cycle 10. Score 00, level 0, state RUN.
2. Two single-cycle eat pulses → score 02, level 1, toggle spacing 7. Two more → level 2, spacing 4. Two more → level 3, spacing stays 4 (floor).
3. Hold `i_eat` high 20 cycles → score increments by exactly 1.
4. 101 eat pulses → score saturates at 8'h99 and does not wrap. Check BCD carry 09→10.
5. Pause at counter=6 for 50 cycles, then release → no toggles during pause; next toggle 4 cycles after resume.
6. Raise `i_failure` and `i_eat` together, then `i_success` → score +1, state LOST (not WON), `o_phase` frozen. Later eats ignored. Async `rst_n` low mid-cycle → all outputs reset immediately.

Source files
------------

// File: rtl/snake_pacer.sv
`default_nettype none
// ============================================================================
// snake_pacer : game-tick phase generator, speed levels and BCD apple score
// Rev 1.0
// ============================================================================
module snake_pacer #(
  parameter int unsigned PERIOD_START     = 6250000,
  parameter int unsigned PERIOD_STEP      = 250000,
  parameter int unsigned PERIOD_MIN       = 1250000,
  parameter int unsigned APPLES_PER_LEVEL = 4,
  parameter int unsigned CNT_W            = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_eat,
  input  logic       i_failure,
  input  logic       i_success,
  input  logic       i_pause,
  output logic       o_phase,
  output logic [7:0] o_score,
  output logic [3:0] o_level,
  output logic [1:0] o_state
);

  localparam logic [1:0]       S_RUN   = 2'd0;
  localparam logic [1:0]       S_PAUSE = 2'd1;
  localparam logic [1:0]       S_LOST  = 2'd2;
  localparam logic [1:0]       S_WON   = 2'd3;

  localparam logic [CNT_W-1:0] P_START = CNT_W'(PERIOD_START);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W:0]   P_STEP  = (CNT_W+1)'(PERIOD_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   EXT_ONE = (CNT_W+1)'(1);
  localparam logic [3:0]       APL     = 4'(APPLES_PER_LEVEL);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             phase_q, phase_d;
  logic [7:0]       score_q, score_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       apples_q, apples_d;
  logic             eat_q;

  logic             count_en;
  logic             eat_en;
  logic             eat_evt;
  logic             cnt_wrap;
  logic [CNT_W:0]   period_sub;
  logic [CNT_W-1:0] period_dec;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN, S_PAUSE: begin
        if      (i_failure) state_d = S_LOST;
        else if (i_success) state_d = S_WON;
        else if (i_pause)   state_d = S_PAUSE;
        else                state_d = S_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    count_en = 1'b0;
    eat_en   = 1'b0;
    case (state_q)
      S_RUN: begin
        count_en = 1'b1;
        eat_en   = 1'b1;
      end
      S_PAUSE: eat_en = 1'b1;
      default: ;
    endcase
  end

  assign o_state = state_q;

  // ---------------- datapath ----------------
  assign eat_evt = i_eat & ~eat_q;
  // Compare at CNT_W+1 bits so a shrunken period below the count still wraps.
  assign cnt_wrap   = ({1'b0, cnt_q} + EXT_ONE) >= {1'b0, period_q};
  assign period_sub = {1'b0, period_q} - P_STEP;
  assign period_dec = (period_sub[CNT_W] || (period_sub[CNT_W-1:0] < P_MIN)) ?
                      P_MIN : period_sub[CNT_W-1:0];

  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    score_d  = score_q;
    level_d  = level_q;
    apples_d = apples_q;
    period_d = period_q;

    if (count_en) begin
      if (cnt_wrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    if (eat_en && eat_evt) begin
      if (score_q != 8'h99) begin
        if (score_q[3:0] == 4'd9) score_d = {score_q[7:4] + 4'd1, 4'd0};
        else                      score_d = {score_q[7:4], score_q[3:0] + 4'd1};
      end
      if ((apples_q + 4'd1) == APL) begin
        apples_d = 4'd0;
        period_d = period_dec;
        if (level_q != 4'hF) level_d = level_q + 4'd1;
      end else begin
        apples_d = apples_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= P_START;
      phase_q  <= 1'b0;
      score_q  <= 8'h00;
      level_q  <= 4'd0;
      apples_q <= 4'd0;
      eat_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      score_q  <= score_d;
      level_q  <= level_d;
      apples_q <= apples_d;
      eat_q    <= i_eat;
    end
  end

  assign o_phase = phase_q;
  assign o_score = score_q;
  assign o_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_pacer.sv
`default_nettype none
// ============================================================================
// tb_snake_pacer : randomized + directed bench against a behavioural model
// Rev 1.0
// ============================================================================
module tb_snake_pacer;

  localparam int PS  = 10;
  localparam int PST = 3;
  localparam int PM  = 4;
  localparam int APL = 2;
  localparam int CW  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_eat = 1'b0;
  logic       i_failure = 1'b0;
  logic       i_success = 1'b0;
  logic       i_pause = 1'b0;
  logic       o_phase;
  logic [7:0] o_score;
  logic [3:0] o_level;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  snake_pacer #(
    .PERIOD_START(PS), .PERIOD_STEP(PST), .PERIOD_MIN(PM),
    .APPLES_PER_LEVEL(APL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_eat(i_eat), .i_failure(i_failure),
    .i_success(i_success), .i_pause(i_pause), .o_phase(o_phase),
    .o_score(o_score), .o_level(o_level), .o_state(o_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  // Model: score as a plain decimal count, period as an integer, elapsed
  // cycles since the last tick, and the game state 0..3.
  int m_score, m_level, m_period, m_elapsed, m_apples, m_state, cyc;
  bit m_phase, m_prev_eat, m_ev, m_live;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score = 0; m_level = 0; m_period = PS; m_elapsed = 0;
      m_apples = 0; m_state = 0; m_phase = 0; m_prev_eat = 0; cyc = 0;
    end else begin
      cyc++;
      m_ev = i_eat && !m_prev_eat;
      m_prev_eat = i_eat;
      m_live = (m_state == 0) || (m_state == 1);
      if (m_state == 0) begin
        m_elapsed++;
        if (m_elapsed >= m_period) begin
          m_elapsed = 0;
          m_phase = !m_phase;
        end
      end
      if (m_live && m_ev) begin
        if (m_score < 99) m_score++;
        m_apples++;
        if (m_apples == APL) begin
          m_apples = 0;
          if (m_level < 15) m_level++;
          m_period = (m_period - PST < PM) ? PM : m_period - PST;
        end
      end
      if (m_live)
        m_state = i_failure ? 2 : i_success ? 3 : i_pause ? 1 : 0;
    end
  end

  // Per-cycle compare and phase-edge bookkeeping.
  bit prev_phase;
  int n_tog, last_tog, spacing, first_tog;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_phase = 0; n_tog = 0; last_tog = 0; spacing = 0; first_tog = -1;
    end else begin
      check("phase", int'(o_phase), int'(m_phase));
      check("score", int'(o_score), to_bcd(m_score));
      check("level", int'(o_level), m_level);
      check("state", int'(o_state), m_state);
      if (o_phase !== prev_phase) begin
        n_tog++;
        if (first_tog < 0) first_tog = cyc;
        spacing  = cyc - last_tog;
        last_tog = cyc;
        prev_phase = o_phase;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_eat(input int n);
    repeat (n) begin
      tick(1); i_eat = 1'b1;
      tick(1); i_eat = 1'b0;
    end
  endtask

  task automatic do_reset();
    tick(1); rst_n = 1'b0;
    tick(2); rst_n = 1'b1;
  endtask

  task automatic random_run(input int n, input bit flags);
    for (int k = 0; k < n; k++) begin
      tick(1);
      i_eat   = ($urandom_range(0, 2) == 0);
      i_pause = ($urandom_range(0, 7) == 0) ? ~i_pause : i_pause;
      if (flags && $urandom_range(0, 99) == 0) i_failure = 1'b1;
      if (flags && $urandom_range(0, 99) == 0) i_success = 1'b1;
    end
    i_eat = 1'b0; i_pause = 1'b0;
  endtask

  int t0, n;

  initial begin
    // 1: reset values, then idle cadence
    tick(3);
    check("rst_score", int'(o_score), 0);
    check("rst_state", int'(o_state), 0);
    rst_n = 1'b1;
    tick(40);
    check("s1_toggles", n_tog, 4);
    check("s1_first", first_tog, 10);
    check("s1_spacing", spacing, 10);
    check("s1_score", int'(o_score), 0);

    // 2: level-ups shrink the period down to the floor
    pulse_eat(2);
    check("s2_score2", int'(o_score), 8'h02);
    check("s2_level1", int'(o_level), 1);
    tick(30);
    check("s2_spacing7", spacing, 7);
    pulse_eat(2);
    check("s2_level2", int'(o_level), 2);
    tick(30);
    check("s2_spacing4", spacing, 4);
    pulse_eat(2);
    check("s2_level3", int'(o_level), 3);
    tick(30);
    check("s2_spacing_floor", spacing, 4);

    // 3: held eat counts once
    i_eat = 1'b1; tick(20); i_eat = 1'b0; tick(2);
    check("s3_held", int'(o_score), 8'h07);

    // 4: BCD carry and saturation
    pulse_eat(2);
    check("s4_09", int'(o_score), 8'h09);
    pulse_eat(1);
    check("s4_carry", int'(o_score), 8'h10);
    pulse_eat(98);
    check("s4_sat", int'(o_score), 8'h99);
    check("s4_level_sat", int'(o_level), 15);

    do_reset();
    random_run(400, 1'b0);

    // 5: pause preserves the remaining count
    do_reset();
    tick(5);
    i_pause = 1'b1;
    tick(1);
    check("s5_paused", int'(o_state), 1);
    t0 = n_tog;
    tick(50);
    check("s5_no_tog", n_tog, t0);
    i_pause = 1'b0;
    tick(1);
    check("s5_resumed", int'(o_state), 0);
    n = 0;
    while (n < 20 && n_tog == t0) begin
      tick(1);
      n++;
    end
    check("s5_resume_to_toggle", n, 4);

    // 6: failure with simultaneous eat, then success; LOST wins
    i_failure = 1'b1; i_eat = 1'b1;
    tick(1);
    i_success = 1'b1; i_eat = 1'b0;
    tick(1);
    check("s6_state_lost", int'(o_state), 2);
    check("s6_score", int'(o_score), 8'h01);
    t0 = n_tog;
    pulse_eat(3);
    tick(30);
    check("s6_frozen", n_tog, t0);
    check("s6_eat_ignored", int'(o_score), 8'h01);
    check("s6_phase_before_rst", int'(o_phase), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_phase", int'(o_phase), 0);
    check("s6_async_score", int'(o_score), 0);
    check("s6_async_state", int'(o_state), 0);
    check("s6_async_level", int'(o_level), 0);
    i_failure = 1'b0; i_success = 1'b0;
    tick(1);
    rst_n = 1'b1;

    random_run(300, 1'b1);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
